instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 6 +
 rtl/instr_fetch_if.sv | 13 +
 rtl/instr_fifo.sv | 52 +++++
 rtl/instr_fetch.sv | 75 +++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch FSM state encoding, NOP word and default reset PC shared by the fetch unit
package instr_fetch_pkg;
   typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} fetch_state_t;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory bus between fetch unit (master) and memory (slave)
//   imem_req   : one-cycle read request
//   imem_addr  : word-aligned fetch address, valid with imem_req
//   imem_valid : response strobe, at least one cycle after the request
//   imem_data  : instruction word, valid with imem_valid
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_data;
   modport master (output imem_req, imem_addr, input imem_valid, imem_data);
   modport slave (input imem_req, imem_addr, output imem_valid, imem_data);
endinterface

// File: rtl/instr_fifo.sv
// instr_fifo: instruction buffer of {pc, instr} entries with push/pop/flush
//   clk_i, rst_i (sync, active-low) ; push_i/data_i write ; pop_i advances head
//   flush_i empties the buffer and wins over same-cycle push/pop
//   data_o is the head entry (all zero when empty) ; full_o/empty_o occupancy flags
module instr_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic        flush_i,
   input  logic [63:0] data_i,
   output logic [63:0] data_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [63:0] mem_q [DEPTH];
   logic [63:0] mem_d [DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   // pointers carry one extra wrap bit so full and empty are distinguishable
   assign empty_o = wr_q == rd_q;
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign data_o  = empty_o ? {32'h0, NOP_WORD} : mem_q[rd_q[AW-1:0]];
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push_i && !full_o) begin
         mem_d[wr_q[AW-1:0]] = data_i;
         wr_d = wr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge clk_i) mem_q <= mem_d;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with single-outstanding memory requests and a small instruction buffer
//   clk_i, rst_i (sync, active-low) ; imem : memory bus master
//   instr_valid_o/instr_o/pc_o/pc_plus4_o : buffer head to decode, consumed with instr_ready_i
//   jr_i > jump_i > branch_taken_i : redirects that flush the buffer and restart fetch at the target
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   instr_fetch_if.master        imem,
   output logic                 instr_valid_o,
   output logic [31:0]          instr_o,
   output logic [31:0]          pc_o,
   output logic [31:0]          pc_plus4_o,
   input  logic                 instr_ready_i,
   input  logic                 branch_taken_i,
   input  logic [31:0]          branch_target_i,
   input  logic                 jump_i,
   input  logic [25:0]          jump_index_i,
   input  logic                 jr_i,
   input  logic [31:0]          jr_target_i
);
   fetch_state_t state_q, state_d;
   logic [31:0]  fpc_q, fpc_d, raddr_q, raddr_d, target;
   logic         redirect, issue, push, pop, full, empty;
   logic [63:0]  head;
   assign redirect = jr_i | jump_i | branch_taken_i;
   assign target   = (jr_i ? jr_target_i : jump_i ? {pc_plus4_o[31:28], jump_index_i, 2'b00} : branch_target_i) & ~32'h3;
   // a redirecting cycle issues nothing so the old fetch PC never reaches memory
   assign issue    = rst_i && state_q == ST_REQ && !full && !redirect;
   assign push     = state_q == ST_WAIT && imem.imem_valid && !redirect;
   assign pop      = instr_valid_o && instr_ready_i;
   assign imem.imem_req  = issue;
   assign imem.imem_addr = issue ? fpc_q : '0;
   assign instr_valid_o  = !empty;
   assign {pc_o, instr_o} = head;
   assign pc_plus4_o     = pc_o + 32'd4;
   always_comb begin
      state_d = state_q;
      fpc_d   = redirect ? target : issue ? fpc_q + 32'd4 : fpc_q;
      raddr_d = issue ? fpc_q : raddr_q;
      // a response landing with the redirect closes the request, so no DROP is needed then
      case (state_q)
         ST_REQ:  state_d = issue ? ST_WAIT : ST_REQ;
         ST_WAIT: state_d = imem.imem_valid ? ST_REQ : redirect ? ST_DROP : ST_WAIT;
         ST_DROP: state_d = imem.imem_valid ? ST_REQ : ST_DROP;
         default: state_d = ST_REQ;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_REQ;
         fpc_q   <= RESET_PC;
         raddr_q <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         raddr_q <= raddr_d;
      end
   end
   instr_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect),
      .data_i  ({raddr_q, imem.imem_data}),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random and directed stimulus against an instruction-stream reference model
module tb_instr_fetch;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, ready, br, jp, jr;
   logic [31:0] bt, jt, instr, pc, pc4, instr2, pc2, pc42;
   logic [25:0] ji;
   logic        instr_valid, instr_valid2;
   instr_fetch_if bus ();
   instr_fetch_if bus2 ();
   instr_fetch dut (
      .clk_i(clk), .rst_i(rst), .imem(bus),
      .instr_valid_o(instr_valid), .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc4),
      .instr_ready_i(ready), .branch_taken_i(br), .branch_target_i(bt),
      .jump_i(jp), .jump_index_i(ji), .jr_i(jr), .jr_target_i(jt)
   );
   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk_i(clk), .rst_i(rst), .imem(bus2),
      .instr_valid_o(instr_valid2), .instr_o(instr2), .pc_o(pc2), .pc_plus4_o(pc42),
      .instr_ready_i(1'b1), .branch_taken_i(1'b0), .branch_target_i(32'h0),
      .jump_i(1'b0), .jump_index_i(26'h0), .jr_i(1'b0), .jr_target_i(32'h0)
   );
   int          n_tests = 0, n_fail = 0, cyc = 0, consumed = 0, vld_c = -1;
   int          lat_min = 1, lat_max = 1, pend_cnt = 0;
   bit          rnd_mode = 0, inj_stale = 0, pend_v = 0, p2_v = 0;
   logic        n_rst = 1'b0, n_rdy = 1'b1, n_br = 1'b0, n_jp = 1'b0, n_jr = 1'b0;
   logic [31:0] n_bt = '0, n_jt = '0, pend_addr = '0, p2_addr = '0, exp_pc = '0;
   logic [25:0] n_ji = '0;
   logic [31:0] req_q[$], req2_q[$], head2_q[$];
   int          req_c[$];
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic pick();
      ready = ($urandom_range(0, 3) != 0);
      jr = 1'b0; jp = 1'b0; br = 1'b0;
      if ($urandom_range(0, 11) == 0) begin
         jr = ($urandom_range(0, 2) == 0);
         jp = instr_valid && ($urandom_range(0, 1) == 1);
         br = ($urandom_range(0, 1) == 1) || !(jr || jp);
      end
      bt = $urandom & 32'h0000_3FFF;
      jt = $urandom & 32'h0000_3FFF;
      ji = 26'($urandom);
   endtask
   task automatic observe();
      logic [31:0] nx;
      if (!rst) begin
         exp_pc = 32'h0; pend_v = 0; p2_v = 0;
         req2_q.delete(); head2_q.delete();
         return;
      end
      if (bus.imem_req) begin
         check("single_outstanding", 32'(pend_v), 32'd0);
         check("addr_aligned", 32'(bus.imem_addr[1:0]), 32'd0);
         pend_v = 1; pend_addr = bus.imem_addr; pend_cnt = $urandom_range(lat_min, lat_max);
         req_q.push_back(bus.imem_addr); req_c.push_back(cyc);
      end
      if (instr_valid) begin
         if (vld_c < 0) vld_c = cyc;
         check("head_pc", pc, exp_pc);
         check("head_instr", instr, mem_word(exp_pc));
         check("pc_plus4", pc4, exp_pc + 32'd4);
         if (ready) consumed++;
      end
      nx = exp_pc + 32'd4;
      if (jr || jp || br) exp_pc = (jr ? jt : jp ? {nx[31:28], ji, 2'b00} : bt) & ~32'h3;
      else if (instr_valid && ready) exp_pc = nx;
      if (bus2.imem_req) begin
         req2_q.push_back(bus2.imem_addr); p2_v = 1; p2_addr = bus2.imem_addr;
      end
      if (instr_valid2) head2_q.push_back(pc2);
   endtask
   task automatic cycle();
      @(posedge clk); #1;
      cyc++;
      rst = n_rst;
      bus.imem_valid = 1'b0; bus.imem_data = '0;
      if (inj_stale) begin
         bus.imem_valid = 1'b1; bus.imem_data = 32'hDEAD_BEEF; inj_stale = 0;
      end else if (pend_v) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            bus.imem_valid = 1'b1; bus.imem_data = mem_word(pend_addr); pend_v = 0;
         end
      end
      bus2.imem_valid = p2_v; bus2.imem_data = mem_word(p2_addr); p2_v = 0;
      if (rnd_mode) pick();
      else begin
         ready = n_rdy; br = n_br; bt = n_bt; jp = n_jp; ji = n_ji; jr = n_jr; jt = n_jt;
      end
      #1;
      observe();
   endtask
   task automatic wait_valid(input string tag);
      int k = 0;
      while (!instr_valid && k < 20) begin cycle(); k++; end
      check(tag, 32'(instr_valid), 32'd1);
   endtask
   task automatic wait_req(input string tag, input logic [31:0] exp);
      int k = 0;
      while (req_q.size() == 0 && k < 20) begin cycle(); k++; end
      check(tag, req_q.size() > 0 ? req_q[0] : 32'hBAD0_0001, exp);
   endtask
   initial begin
      int rel, k, c0;
      rst = 1'b0; ready = 1'b1; br = 1'b0; jp = 1'b0; jr = 1'b0; bt = '0; jt = '0; ji = '0;
      bus.imem_valid = 1'b0; bus.imem_data = '0; bus2.imem_valid = 1'b0; bus2.imem_data = '0;
      repeat (2) cycle();
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_addr", bus.imem_addr, 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_pc4", pc4, 32'd4);
      // sequential fetch with one-cycle memory
      req_q.delete(); req_c.delete(); vld_c = -1;
      n_rst = 1'b1;
      cycle();
      rel = cyc;
      repeat (7) cycle();
      check("seq_req_count", 32'(req_q.size() >= 3), 32'd1);
      if (req_q.size() >= 3) begin
         check("first_req_cycle", 32'(req_c[0]), 32'(rel));
         check("seq_addr0", req_q[0], 32'h0);
         check("seq_addr1", req_q[1], 32'h4);
         check("seq_addr2", req_q[2], 32'h8);
         check("seq_gap1", 32'(req_c[1] - req_c[0]), 32'd2);
         check("seq_gap2", 32'(req_c[2] - req_c[1]), 32'd2);
      end
      check("fetch_to_valid", 32'(vld_c), 32'(rel + 2));
      // decoder stall fills the buffer then stops requesting
      n_rst = 1'b0; cycle();
      n_rst = 1'b1; n_rdy = 1'b0; req_q.delete();
      repeat (10) cycle();
      check("stall_req_count", 32'(req_q.size()), 32'd2);
      check("stall_req_low", 32'(bus.imem_req), 32'd0);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", pc, 32'h0);
      check("stall_instr", instr, mem_word(32'h0));
      n_rdy = 1'b1;
      repeat (6) cycle();
      // jump from a head at 0x1000_0040
      n_rdy = 1'b0; n_jr = 1'b1; n_jt = 32'h1000_0040;
      cycle();
      n_jr = 1'b0;
      wait_valid("jr_head_valid");
      check("jr_head_pc", pc, 32'h1000_0040);
      n_jp = 1'b1; n_ji = 26'h000_0100; req_q.delete();
      cycle();
      n_jp = 1'b0;
      cycle();
      check("jump_flush", 32'(instr_valid), 32'd0);
      wait_req("jump_addr", 32'h1000_0400);
      n_rdy = 1'b1;
      wait_valid("jump_head_valid");
      // branch while a request is outstanding
      lat_min = 3; lat_max = 3; req_q.delete(); k = 0;
      while (req_q.size() == 0 && k < 20) begin cycle(); k++; end
      check("branch_req_seen", 32'(req_q.size() > 0), 32'd1);
      n_br = 1'b1; n_bt = 32'h0000_0203; req_q.delete();
      cycle();
      n_br = 1'b0;
      wait_req("branch_addr", 32'h0000_0200);
      wait_valid("branch_head_valid");
      check("branch_head_pc", pc, 32'h0000_0200);
      // jr wins over a same-cycle branch
      lat_min = 1; lat_max = 2;
      n_jr = 1'b1; n_jt = 32'h0000_0080; n_br = 1'b1; n_bt = 32'h0000_0400; req_q.delete();
      cycle();
      n_jr = 1'b0; n_br = 1'b0;
      wait_req("jr_priority_addr", 32'h0000_0080);
      // reset mid-request with a stale response right after
      req_q.delete(); k = 0;
      while (req_q.size() == 0 && k < 20) begin cycle(); k++; end
      n_rst = 1'b0; cycle();
      n_rst = 1'b1; inj_stale = 1; req_q.delete();
      cycle();
      check("post_rst_first_req", req_q.size() > 0 ? req_q[0] : 32'hBAD0_0001, 32'h0);
      wait_valid("post_rst_valid");
      check("stale_ignored", instr, mem_word(32'h0));
      // randomized run
      lat_min = 1; lat_max = 3; c0 = consumed; rnd_mode = 1;
      repeat (3000) cycle();
      rnd_mode = 0;
      check("random_progress", 32'(consumed - c0 > 100), 32'd1);
      // wrap-around instance
      check("wrap_req_count", 32'(req2_q.size() >= 3 && head2_q.size() >= 2), 32'd1);
      if (req2_q.size() >= 3 && head2_q.size() >= 2) begin
         check("wrap_addr0", req2_q[0], 32'hFFFF_FFFC);
         check("wrap_addr1", req2_q[1], 32'h0);
         check("wrap_addr2", req2_q[2], 32'h4);
         check("wrap_head0", head2_q[0], 32'hFFFF_FFFC);
         check("wrap_head1", head2_q[1], 32'h0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
